// File: rtl/fnd_scan_ctrl_if.sv
// Display bus between the up-counter and the FND scan controller.
// The master drives the binary count; the slave drives the digit enables and segments.
interface fnd_scan_ctrl_if #(
  parameter int unsigned CNT_W = 14
);
  logic [CNT_W-1:0] count;
  logic [3:0]       seg_comm;
  logic [7:0]       seg;

  modport master (output count, input seg_comm, input seg);
  modport slave  (input count, output seg_comm, output seg);
endinterface

// File: rtl/fnd_scan_ctrl.sv
// 4-digit common-anode FND scan controller.
// A free-running double-dabble converter turns the clamped binary count into BCD. A prescaled
// scan tick rotates the active digit. The shown digits change only at frame boundaries.
// Optional feature: define FND_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module fnd_scan_ctrl #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 4_000,
  parameter int unsigned CNT_W   = 14,
  parameter int unsigned MAX_VAL = 9999
) (
  input logic           clk,
  input logic           reset,
  fnd_scan_ctrl_if.slave bus
);
  localparam int unsigned Div  = CLK_HZ / SCAN_HZ;
  localparam int unsigned PsW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned BitW = $clog2(CNT_W + 1);
  localparam logic [PsW-1:0]   PsLast  = PsW'(Div - 1);
  localparam logic [CNT_W-1:0] MaxV    = CNT_W'(MAX_VAL);
  localparam logic [BitW-1:0]  BitLast = BitW'(CNT_W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} conv_st_e;

  logic [PsW-1:0]      ps_q;
  logic                scan_tick;
  logic [1:0]          idx_q, idx_d;
  logic [15:0]         shown_q, shown_d;
  logic [3:0]          seg_comm_q;
  logic [7:0]          seg_q;
  conv_st_e            state_q, state_d;
  logic [CNT_W-1:0]    bin_q, bin_d;
  logic [15:0]         bcd_q, bcd_d, bcd_adj;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [15:0]         pend_q, pend_d;
  logic [16+CNT_W-1:0] shifted;
  logic [3:0]          digit;
  logic                blank;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  assign scan_tick = (ps_q == PsLast);

  // Prescaler: wraps on its terminal count, which is the scan tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ps_q <= '0;
    end else if (scan_tick) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_q + 1'b1;
    end
  end

  // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {bcd_adj, bin_q} << 1;

  // Converter next state: capture, shift CNT_W times, publish to pending.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    bit_d   = bit_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        bin_d   = (bus.count > MaxV) ? MaxV : bus.count;
        bcd_d   = '0;
        bit_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        bcd_d = shifted[16+CNT_W-1 -: 16];
        bin_d = shifted[CNT_W-1:0];
        bit_d = bit_q + 1'b1;
        if (bit_q == BitLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        pend_d  = bcd_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Converter state register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      bit_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      bit_q   <= bit_d;
      pend_q  <= pend_d;
    end
  end

  // Next digit index; shown digits reload from the pre-DONE pending value on the 3->0 wrap.
  always_comb begin
    idx_d   = scan_tick ? idx_q + 2'd1 : idx_q;
    shown_d = (scan_tick && idx_q == 2'd3) ? pend_q : shown_q;
    digit   = shown_d[{idx_d, 2'b00} +: 4];
  end

  // Leading-zero blanking of the upper three digits when enabled.
  always_comb begin
    blank = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
    case (idx_d)
      2'd3:    blank = (shown_d[15:12] == 4'd0);
      2'd2:    blank = (shown_d[15:8] == 8'd0);
      2'd1:    blank = (shown_d[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`endif
  end

  // Scan registers; outputs update together with the index on each tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q      <= 2'd0;
      shown_q    <= '0;
      seg_comm_q <= 4'b1111;
      seg_q      <= 8'hFF;
    end else begin
      idx_q   <= idx_d;
      shown_q <= shown_d;
      if (scan_tick) begin
        seg_comm_q <= ~(4'b0001 << idx_d);
        seg_q      <= blank ? 8'hFF : seg_decode(digit);
      end
    end
  end

  assign bus.seg_comm = seg_comm_q;
  assign bus.seg      = seg_q;
endmodule
